// File: rtl/obj_lane_engine.sv
// rtl/obj_lane_engine.sv - paddle, falling-object lanes, score/miss totals and game-over for the play screen
module obj_lane_engine #(
  parameter int          N_OBJ       = 4,
  parameter int          TICK_DIV    = 1048576,
  parameter int          SCREEN_W    = 640,
  parameter int          PLAYER_W    = 100,
  parameter int          PLAYER_Y    = 379,
  parameter int          OBJ_W       = 32,
  parameter int          OBJ_H       = 32,
  parameter int          P_STEP      = 4,
  parameter int          FALL_STEP   = 3,
  parameter int          STAGGER     = 50,
  parameter int          RESPAWN_GAP = 20,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          SCORE_W     = 8,
  parameter int          MISS_LIMIT  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            state,
  input  logic [1:0]            dir,
  output logic [11:0]           player_x,
  output logic [12*N_OBJ-1:0]   obj_x,
  output logic [12*N_OBJ-1:0]   obj_y,
  output logic [N_OBJ-1:0]      obj_active,
  output logic [SCORE_W-1:0]    score,
  output logic [SCORE_W-1:0]    miss,
  output logic                  game_over
);

  localparam int DIV_W     = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam int CNT_MAX   = ((N_OBJ - 1) * STAGGER > RESPAWN_GAP) ? (N_OBJ - 1) * STAGGER : RESPAWN_GAP;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int P_MAX     = SCREEN_W - PLAYER_W;
  localparam int X_RANGE   = SCREEN_W - OBJ_W + 1;
  localparam int Y_RESOLVE = PLAYER_Y - OBJ_H;
  localparam int SUM_W     = SCORE_W + 4;
  localparam logic [SUM_W-1:0] SAT = SUM_W'((1 << SCORE_W) - 1);

  typedef enum logic {L_WAIT = 1'b0, L_FALL = 1'b1} lane_state_t;

  logic [DIV_W-1:0]   r_div, w_div_n;
  logic [11:0]        r_px, w_px_n;
  lane_state_t        r_ls [N_OBJ];
  lane_state_t        w_ls_n [N_OBJ];
  logic [CNT_W-1:0]   r_cnt [N_OBJ];
  logic [CNT_W-1:0]   w_cnt_n [N_OBJ];
  logic [15:0]        r_lfsr [N_OBJ];
  logic [15:0]        w_lfsr_n [N_OBJ];
  logic [11:0]        r_ox [N_OBJ];
  logic [11:0]        w_ox_n [N_OBJ];
  logic [11:0]        r_oy [N_OBJ];
  logic [11:0]        w_oy_n [N_OBJ];
  logic [N_OBJ-1:0]   r_act, w_act_n;
  logic [SCORE_W-1:0] r_score, w_score_n;
  logic [SCORE_W-1:0] r_miss, w_miss_n;
  logic               r_go, w_go_n;
  logic               w_play, w_pause, w_clear, w_tick, w_upd;
  logic [N_OBJ-1:0]   w_catch, w_lost;
  logic [3:0]         w_n_catch, w_n_lost;
  logic [SUM_W-1:0]   w_score_sum, w_miss_sum;

  // Lane seeds are spread by a per-lane constant; the all-zero LFSR lock-up state is avoided.
  function automatic logic [15:0] seed_of(input int i);
    logic [15:0] s;
    s = SEED ^ 16'(i * 32'h1F35);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] galois_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  // 12-bit random value folded into the spawn range; seven subtractions cover 4095.
  function automatic logic [11:0] wrap_x(input logic [11:0] r);
    logic [11:0] v;
    v = r;
    for (int k = 0; k < 7; k++) begin
      if (v >= 12'(X_RANGE)) v = v - 12'(X_RANGE);
    end
    return v;
  endfunction

  function automatic logic overlap(input logic [11:0] ox, input logic [11:0] px);
    return (({1'b0, ox} + 13'(OBJ_W)) > {1'b0, px}) && ({1'b0, ox} < ({1'b0, px} + 13'(PLAYER_W)));
  endfunction

  assign w_play  = (state == 3'b010);
  assign w_pause = (state == 3'b100) || (state == 3'b110);
  assign w_clear = !(w_play || w_pause);
  assign w_tick  = w_play && (r_div == DIV_LAST);
  assign w_upd   = w_tick && !r_go;

  // Next-state for divider, paddle, every lane and the totals.
  always_comb begin
    w_div_n   = r_div;
    w_px_n    = r_px;
    w_act_n   = r_act;
    w_go_n    = r_go;
    w_catch   = '0;
    w_lost    = '0;
    w_n_catch = 4'd0;
    w_n_lost  = 4'd0;
    for (int i = 0; i < N_OBJ; i++) begin
      w_ls_n[i]   = r_ls[i];
      w_cnt_n[i]  = r_cnt[i];
      w_lfsr_n[i] = r_lfsr[i];
      w_ox_n[i]   = r_ox[i];
      w_oy_n[i]   = r_oy[i];
    end

    if (w_play) w_div_n = w_tick ? '0 : r_div + DIV_W'(1);

    if (w_upd) begin
      if (dir == 2'b01) begin
        w_px_n = (r_px >= 12'(P_STEP)) ? r_px - 12'(P_STEP) : 12'd0;
      end else if (dir == 2'b10) begin
        w_px_n = (({1'b0, r_px} + 13'(P_STEP)) > 13'(P_MAX)) ? 12'(P_MAX) : r_px + 12'(P_STEP);
      end

      for (int i = 0; i < N_OBJ; i++) begin
        case (r_ls[i])
          L_WAIT: begin
            if (r_cnt[i] == '0) begin
              w_ls_n[i]   = L_FALL;
              w_act_n[i]  = 1'b1;
              w_oy_n[i]   = 12'd0;
              w_ox_n[i]   = wrap_x(r_lfsr[i][11:0]);
              w_lfsr_n[i] = galois_step(r_lfsr[i]);
            end else begin
              w_cnt_n[i] = r_cnt[i] - CNT_W'(1);
            end
          end
          default: begin
            w_oy_n[i] = r_oy[i] + 12'(FALL_STEP);
            if ((r_oy[i] + 12'(FALL_STEP)) >= 12'(Y_RESOLVE)) begin
              // Overlap uses the paddle position from before this tick's move.
              w_catch[i] = overlap(r_ox[i], r_px);
              w_lost[i]  = !overlap(r_ox[i], r_px);
              w_act_n[i] = 1'b0;
              w_cnt_n[i] = CNT_W'(RESPAWN_GAP - 1);
              w_ls_n[i]  = L_WAIT;
            end
          end
        endcase
      end
    end

    for (int i = 0; i < N_OBJ; i++) begin
      w_n_catch = w_n_catch + {3'b000, w_catch[i]};
      w_n_lost  = w_n_lost + {3'b000, w_lost[i]};
    end

    w_score_sum = SUM_W'(r_score) + SUM_W'(w_n_catch);
    w_miss_sum  = SUM_W'(r_miss) + SUM_W'(w_n_lost);
    w_score_n   = (w_score_sum > SAT) ? SAT[SCORE_W-1:0] : w_score_sum[SCORE_W-1:0];
    w_miss_n    = (w_miss_sum > SAT) ? SAT[SCORE_W-1:0] : w_miss_sum[SCORE_W-1:0];

    if (w_upd && (32'(w_miss_n) >= 32'(MISS_LIMIT))) w_go_n = 1'b1;
  end

  // State registers; reset and idle both restore the power-on state in one cycle.
  always_ff @(posedge clk) begin
    if (!rst || w_clear) begin
      r_div   <= '0;
      r_px    <= 12'(P_MAX / 2);
      r_act   <= '0;
      r_score <= '0;
      r_miss  <= '0;
      r_go    <= 1'b0;
      for (int i = 0; i < N_OBJ; i++) begin
        r_ls[i]   <= L_WAIT;
        r_cnt[i]  <= CNT_W'(i * STAGGER);
        r_lfsr[i] <= seed_of(i);
        r_ox[i]   <= 12'd0;
        r_oy[i]   <= 12'd0;
      end
    end else begin
      r_div   <= w_div_n;
      r_px    <= w_px_n;
      r_act   <= w_act_n;
      r_score <= w_score_n;
      r_miss  <= w_miss_n;
      r_go    <= w_go_n;
      for (int i = 0; i < N_OBJ; i++) begin
        r_ls[i]   <= w_ls_n[i];
        r_cnt[i]  <= w_cnt_n[i];
        r_lfsr[i] <= w_lfsr_n[i];
        r_ox[i]   <= w_ox_n[i];
        r_oy[i]   <= w_oy_n[i];
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_OBJ; g++) begin : g_pack
      assign obj_x[12*g +: 12] = r_ox[g];
      assign obj_y[12*g +: 12] = r_oy[g];
    end
  endgenerate

  assign player_x   = r_px;
  assign obj_active = r_act;
  assign score      = r_score;
  assign miss       = r_miss;
  assign game_over  = r_go;

endmodule

// File: tb/tb_obj_lane_engine.sv
// tb/tb_obj_lane_engine.sv - randomized self-checking bench for obj_lane_engine against a tick-level game model
module tb_obj_lane_engine;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [1:0]  dir;
  logic [11:0] a_px, b_px;
  logic [47:0] a_ox, a_oy, b_ox, b_oy;
  logic [3:0]  a_act, b_act;
  logic [7:0]  a_sc, a_ms;
  logic [2:0]  b_sc, b_ms;
  logic        a_go, b_go;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  obj_lane_engine #(.N_OBJ(4), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .state(state), .dir(dir), .player_x(a_px), .obj_x(a_ox), .obj_y(a_oy),
    .obj_active(a_act), .score(a_sc), .miss(a_ms), .game_over(a_go));

  obj_lane_engine #(.N_OBJ(4), .TICK_DIV(4), .STAGGER(0), .SCORE_W(3), .MISS_LIMIT(200)) dut_b (
    .clk(clk), .rst(rst), .state(state), .dir(dir), .player_x(b_px), .obj_x(b_ox), .obj_y(b_oy),
    .obj_active(b_act), .score(b_sc), .miss(b_ms), .game_over(b_go));

  // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b; state is advanced once per clock edge.
  int          m_px [2], m_sc [2], m_ms [2], m_div [2];
  bit          m_go [2];
  bit          m_tick;
  int          m_x [2][N], m_y [2][N], m_cnt [2][N];
  bit          m_act [2][N], m_fall [2][N];
  logic [15:0] m_lfsr [2][N];

  function automatic int stg(input int k);  return (k == 0) ? 50 : 0;   endfunction
  function automatic int satv(input int k); return (k == 0) ? 255 : 7;  endfunction
  function automatic int lim(input int k);  return (k == 0) ? 10 : 200; endfunction

  task automatic model_reset(input int k);
    logic [15:0] s;
    m_px[k] = 270; m_sc[k] = 0; m_ms[k] = 0; m_div[k] = 0; m_go[k] = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_x[k][i] = 0; m_y[k][i] = 0; m_act[k][i] = 1'b0; m_fall[k][i] = 1'b0;
      m_cnt[k][i] = i * stg(k);
      s = 16'hACE1 ^ 16'(i * 32'h1F35);
      m_lfsr[k][i] = (s == 16'h0000) ? 16'h0001 : s;
    end
  endtask

  task automatic model_edge(input int k);
    int c, m, old;
    bit tick;
    if (!rst || !(state == 3'b010 || state == 3'b100 || state == 3'b110)) begin
      model_reset(k);
      if (k == 0) m_tick = 1'b0;
      return;
    end
    if (state != 3'b010) begin
      if (k == 0) m_tick = 1'b0;
      return;
    end
    tick = (m_div[k] == 3);
    m_div[k] = tick ? 0 : m_div[k] + 1;
    if (k == 0) m_tick = tick;
    if (!tick || m_go[k]) return;
    old = m_px[k];
    if (dir == 2'b01) m_px[k] = (old - 4 < 0) ? 0 : old - 4;
    else if (dir == 2'b10) m_px[k] = (old + 4 > 540) ? 540 : old + 4;
    c = 0; m = 0;
    for (int i = 0; i < N; i++) begin
      if (!m_fall[k][i]) begin
        if (m_cnt[k][i] == 0) begin
          m_fall[k][i] = 1'b1; m_act[k][i] = 1'b1; m_y[k][i] = 0;
          m_x[k][i] = int'(m_lfsr[k][i][11:0]) % 609;
          m_lfsr[k][i] = (m_lfsr[k][i] >> 1) ^ (m_lfsr[k][i][0] ? 16'hB400 : 16'h0000);
        end else begin
          m_cnt[k][i] = m_cnt[k][i] - 1;
        end
      end else begin
        m_y[k][i] = m_y[k][i] + 3;
        if (m_y[k][i] >= 347) begin
          if (m_x[k][i] + 32 > old && m_x[k][i] < old + 100) c++; else m++;
          m_act[k][i] = 1'b0; m_cnt[k][i] = 19; m_fall[k][i] = 1'b0;
        end
      end
    end
    m_sc[k] = (m_sc[k] + c > satv(k)) ? satv(k) : m_sc[k] + c;
    m_ms[k] = (m_ms[k] + m > satv(k)) ? satv(k) : m_ms[k] + m;
    if (m_ms[k] >= lim(k)) m_go[k] = 1'b1;
  endtask

  function automatic logic [47:0] exp_x(input int k);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[12*i +: 12] = 12'(m_x[k][i]);
    return v;
  endfunction

  function automatic logic [47:0] exp_y(input int k);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[12*i +: 12] = 12'(m_y[k][i]);
    return v;
  endfunction

  function automatic logic [3:0] exp_act(input int k);
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i] = m_act[k][i];
    return v;
  endfunction

  // Paddle chaser: heads for the lowest falling object of dut_a.
  function automatic logic [1:0] steer();
    int best, by, tgt;
    best = -1; by = -1;
    for (int i = 0; i < N; i++) begin
      if (m_fall[0][i] && m_y[0][i] > by) begin by = m_y[0][i]; best = i; end
    end
    if (best < 0) return 2'b00;
    tgt = m_x[0][best] + 16 - 50;
    if (m_px[0] < tgt - 3) return 2'b10;
    if (m_px[0] > tgt + 3) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; state = 3'b010; dir = 2'b00;
    model_reset(0); model_reset(1);
    step(); step();
    checks++; if (a_px !== 12'd270) begin errors++; $display("FAIL reset_px: got %0d expected 270", a_px); end
    checks++; if (a_ox !== 48'd0) begin errors++; $display("FAIL reset_ox: got %h expected 0", a_ox); end
    checks++; if (a_oy !== 48'd0) begin errors++; $display("FAIL reset_oy: got %h expected 0", a_oy); end
    checks++; if (a_act !== 4'd0) begin errors++; $display("FAIL reset_act: got %b expected 0000", a_act); end
    checks++; if ({a_sc, a_ms} !== 16'd0) begin errors++; $display("FAIL reset_totals: got %0d/%0d expected 0/0", a_sc, a_ms); end
    checks++; if (a_go !== 1'b0) begin errors++; $display("FAIL reset_go: got %b expected 0", a_go); end
    checks++; if ({b_px, b_act, b_sc, b_ms, b_go} !== {12'd270, 11'd0}) begin errors++; $display("FAIL reset_b: got px=%0d act=%b expected 270/0", b_px, b_act); end
  endtask

  task automatic test_spawn();
    int ticks;
    rst = 1'b1; state = 3'b010; dir = 2'b00;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (a_act !== 4'b0000) begin errors++; $display("FAIL spawn_early_act: cycle %0d got %b expected 0000", c, a_act); end
    end
    step();
    checks++; if (a_act !== 4'b0001) begin errors++; $display("FAIL spawn_lane0: got %b expected 0001", a_act); end
    checks++; if (b_act !== 4'b1111) begin errors++; $display("FAIL spawn_b_all: got %b expected 1111", b_act); end
    checks++; if (a_oy !== 48'd0) begin errors++; $display("FAIL spawn_y: got %h expected 0", a_oy); end
    checks++; if (a_ox !== exp_x(0)) begin errors++; $display("FAIL spawn_x: got %h expected %h", a_ox, exp_x(0)); end
    checks++; if (b_ox !== exp_x(1)) begin errors++; $display("FAIL spawn_b_x: got %h expected %h", b_ox, exp_x(1)); end
    checks++; if (a_px !== 12'd270) begin errors++; $display("FAIL spawn_px: got %0d expected 270", a_px); end
    ticks = 1;
    for (int c = 0; c < 400 && ticks < 51; c++) begin
      step();
      if (m_tick) ticks++;
      checks++; if (a_act !== exp_act(0) || a_oy !== exp_y(0)) begin errors++; $display("FAIL spawn_track: got act=%b y=%h expected act=%b y=%h", a_act, a_oy, exp_act(0), exp_y(0)); end
      if (m_tick && ticks == 50) begin
        checks++; if (a_act[1] !== 1'b0) begin errors++; $display("FAIL spawn_lane1_early: got %b expected 0", a_act[1]); end
      end
    end
    checks++; if (a_act[1] !== 1'b1 || ticks != 51) begin errors++; $display("FAIL spawn_lane1: got %b after %0d ticks expected 1 after 51", a_act[1], ticks); end
  endtask

  task automatic test_paddle();
    int ticks;
    state = 3'b000; step();
    state = 3'b010;
    for (int phase = 0; phase < 2; phase++) begin
      dir = (phase == 0) ? 2'b10 : 2'b01;
      ticks = 0;
      for (int c = 0; c < 2000 && ticks < 200; c++) begin
        step();
        if (m_tick) ticks++;
        checks++; if (a_px !== 12'(m_px[0]) || a_px > 12'd540) begin errors++; $display("FAIL paddle_track: got %0d expected %0d", a_px, m_px[0]); end
      end
      if (phase == 0) begin
        checks++; if (a_px !== 12'd540) begin errors++; $display("FAIL paddle_right_clamp: got %0d expected 540", a_px); end
      end else begin
        checks++; if (a_px !== 12'd0) begin errors++; $display("FAIL paddle_left_clamp: got %0d expected 0", a_px); end
      end
    end
  endtask

  task automatic test_pause();
    logic [47:0] hold_y;
    int c;
    state = 3'b000; dir = 2'b00; step();
    state = 3'b010;
    c = 0;
    while (m_y[0][0] < 30 && c < 2000) begin step(); c++; end
    checks++; if (a_oy[11:0] < 12'd30) begin errors++; $display("FAIL pause_setup: got y=%0d expected >=30", a_oy[11:0]); end
    for (int k = 0; k < int'($urandom_range(0, 3)); k++) step();
    hold_y = a_oy;
    for (int k = 0; k < 100; k++) begin
      state = (k < 50) ? 3'b100 : 3'b110;
      dir = 2'($urandom);
      step();
      checks++; if (a_oy !== hold_y || a_oy !== exp_y(0)) begin errors++; $display("FAIL pause_hold: got %h expected %h", a_oy, hold_y); end
    end
    state = 3'b010; dir = 2'b00;
    for (int k = 0; k < 40; k++) begin
      step();
      checks++; if (a_oy !== exp_y(0) || a_act !== exp_act(0) || a_ox !== exp_x(0)) begin errors++; $display("FAIL pause_resume: got y=%h expected %h", a_oy, exp_y(0)); end
    end
  endtask

  task automatic test_rst_midfall();
    int c;
    c = 0;
    while (m_y[0][0] < 60 && c < 2000) begin step(); c++; end
    rst = 1'b0; step();
    checks++; if (a_px !== 12'd270 || a_ox !== 48'd0 || a_oy !== 48'd0) begin errors++; $display("FAIL rst_mid_pos: got px=%0d y=%h expected 270/0", a_px, a_oy); end
    checks++; if (a_act !== 4'd0 || a_sc !== 8'd0 || a_ms !== 8'd0 || a_go !== 1'b0) begin errors++; $display("FAIL rst_mid_flags: got act=%b sc=%0d ms=%0d expected 0", a_act, a_sc, a_ms); end
    rst = 1'b1;
  endtask

  task automatic test_random();
    int ticks;
    ticks = 0;
    state = 3'b010;
    for (int c = 0; c < 14000 && !(m_go[0] && ticks >= 400); c++) begin
      dir = (ticks < 400 && $urandom_range(0, 3) != 0) ? steer() : 2'($urandom);
      step();
      if (m_tick) ticks++;
      checks++; if (a_px !== 12'(m_px[0]) || a_ox !== exp_x(0) || a_oy !== exp_y(0)) begin errors++; $display("FAIL rnd_a_pos: got px=%0d y=%h expected px=%0d y=%h", a_px, a_oy, m_px[0], exp_y(0)); end
      checks++; if (a_act !== exp_act(0) || a_sc !== 8'(m_sc[0]) || a_ms !== 8'(m_ms[0]) || a_go !== m_go[0]) begin errors++; $display("FAIL rnd_a_state: got act=%b sc=%0d ms=%0d go=%b expected act=%b sc=%0d ms=%0d go=%b", a_act, a_sc, a_ms, a_go, exp_act(0), m_sc[0], m_ms[0], m_go[0]); end
      checks++; if (b_px !== 12'(m_px[1]) || b_ox !== exp_x(1) || b_oy !== exp_y(1) || b_act !== exp_act(1)) begin errors++; $display("FAIL rnd_b_pos: got px=%0d act=%b expected px=%0d act=%b", b_px, b_act, m_px[1], exp_act(1)); end
      checks++; if (b_sc !== 3'(m_sc[1]) || b_ms !== 3'(m_ms[1]) || b_go !== 1'b0) begin errors++; $display("FAIL rnd_b_totals: got sc=%0d ms=%0d go=%b expected sc=%0d ms=%0d go=0", b_sc, b_ms, b_go, m_sc[1], m_ms[1]); end
    end
    checks++; if (a_go !== 1'b1) begin errors++; $display("FAIL rnd_game_over_timeout: got %b expected 1", a_go); end
  endtask

  task automatic test_game_over();
    logic [11:0] hold_px;
    logic [47:0] hold_y;
    logic [3:0]  hold_act;
    int ticks;
    hold_px = a_px; hold_y = a_oy; hold_act = a_act;
    checks++; if (a_ms < 8'd10 || a_ms !== 8'(m_ms[0])) begin errors++; $display("FAIL go_miss: got %0d expected %0d (>=10)", a_ms, m_ms[0]); end
    ticks = 0;
    for (int c = 0; c < 400 && ticks < 30; c++) begin
      dir = 2'($urandom);
      step();
      if (m_tick) ticks++;
      if (m_go[0]) begin
        checks++; if (a_px !== hold_px || a_oy !== hold_y || a_act !== hold_act) begin errors++; $display("FAIL go_frozen: got px=%0d y=%h expected px=%0d y=%h", a_px, a_oy, hold_px, hold_y); end
      end
      checks++; if (a_go !== m_go[0]) begin errors++; $display("FAIL go_sticky: got %b expected %b", a_go, m_go[0]); end
    end
  endtask

  task automatic test_idle();
    state = 3'b000; step();
    checks++; if (a_px !== 12'd270 || a_oy !== 48'd0 || a_ox !== 48'd0) begin errors++; $display("FAIL idle_pos: got px=%0d y=%h expected 270/0", a_px, a_oy); end
    checks++; if (a_act !== 4'd0 || a_sc !== 8'd0 || a_ms !== 8'd0 || a_go !== 1'b0) begin errors++; $display("FAIL idle_flags: got act=%b sc=%0d ms=%0d go=%b expected 0", a_act, a_sc, a_ms, a_go); end
    checks++; if (b_act !== 4'd0 || b_sc !== 3'd0 || b_ms !== 3'd0) begin errors++; $display("FAIL idle_b: got act=%b sc=%0d ms=%0d expected 0", b_act, b_sc, b_ms); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_paddle();
    test_pause();
    test_rst_midfall();
    test_random();
    test_game_over();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obj_lane_engine.md
Name: obj_lane_engine

Overview:
- Parametrised game-logic core for the play screen: one player paddle plus N_OBJ independently falling objects. Replaces fixed two-object handling.
- Handles player movement from dir, per-lane spawn with staggered start, fall, catch/miss resolution, saturating score/miss totals and game-over.
- Drives coordinates to the VGA renderer. Contains no pixel or memory logic.

Parameters:
- N_OBJ, 4, number of object lanes (1..8)
- TICK_DIV, 1048576, clk cycles per game tick (>=2)
- SCREEN_W, 640, playfield width in pixels
- PLAYER_W, 100, paddle width; PLAYER_Y, 379, paddle top row
- OBJ_W, 32, object width; OBJ_H, 32, object height
- P_STEP, 4, paddle pixels per tick
- FALL_STEP, 3, object pixels per tick
- STAGGER, 50, ticks between successive lanes' first spawn
- RESPAWN_GAP, 20, ticks between a lane resolving and its respawn
- SEED, 16'hACE1, base LFSR seed
- SCORE_W, 8, width of score and miss
- MISS_LIMIT, 10, miss count that ends the game

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- state  in  3  game state: 3'b010 play; 3'b100 or 3'b110 pause; anything else idle
- dir  in  2  2'b01 left, 2'b10 right, 2'b00/2'b11 hold
- player_x  out  12  paddle left x
- obj_x  out  12*N_OBJ  lane i occupies bits [12i+11:12i]
- obj_y  out  12*N_OBJ  same packing as obj_x
- obj_active  out  N_OBJ  lane object visible
- score  out  SCORE_W  total catches
- miss  out  SCORE_W  total misses
- game_over  out  1  sticky end flag

Behaviour:
- Reset is synchronous, active-low, sampled on rising clk. Idle state has the same effect as reset.
- Reset values: player_x=(SCREEN_W-PLAYER_W)/2; obj_x=0; obj_y=0; obj_active=0; score=0; miss=0; game_over=0; tick divider=0; lane i spawn counter=i*STAGGER.
- LFSR for lane i resets to SEED^(i*16'h1F35). If that value is 0, it resets to 16'h0001 instead.
- Tick generation: a free-running divider runs only in play. It emits a 1-cycle tick at count TICK_DIV-1, then wraps to 0. In pause, the divider and all game state hold.
- All updates below happen only on tick cycles with state==3'b010 and game_over==0. Outputs are registered and change 1 cycle after the tick cycle.
- Paddle update:
  - Left: player_x -= P_STEP, clamped at 0.
  - Right: player_x += P_STEP, clamped at SCREEN_W-PLAYER_W.
  - Clamping is computed in 13 bits, with no wrap.
- Lane FSM, per lane:
  - WAIT: decrement the spawn counter. When it is 0 on a tick, go to FALL.
    - obj_y=0; obj_active=1.
    - r = LFSR[11:0]; obj_x = r mod (SCREEN_W-OBJ_W+1), using repeated conditional subtraction, at most 7 subtractions.
    - LFSR advances one Galois step, taps 16'hB400.
  - FALL: obj_y += FALL_STEP. If the new y >= PLAYER_Y-OBJ_H, resolve in this same tick:
    - Overlap test: obj_x+OBJ_W > player_x AND obj_x < player_x+PLAYER_W, using the pre-update player_x.
    - Overlap true is a catch; otherwise a miss.
    - obj_active=0, obj_y is held, spawn counter=RESPAWN_GAP-1, go to WAIT.
- Totals:
  - On each tick, score += number of lanes catching that tick and miss += number of lanes missing that tick. Counts are popcounts over all lanes.
  - Both saturate at 2^SCORE_W-1.
  - Catch and miss in the same tick are both applied.
- game_over is set on the tick where the updated miss >= MISS_LIMIT.
  - From then on, paddle and lanes freeze and obj_active is held.
  - game_over clears only on reset or idle.
- Reset or idle takes effect immediately, mid-fall or mid-tick, with no partial update.
- Pause to play resumes with the divider count preserved.

Test Plan:
- Reset, then play with TICK_DIV=4, dir=00 -> player_x=270; lane0 active after 1 tick; lane1 active after STAGGER+1 ticks; ticks exactly every 4 clk.
- dir=10 held 200 ticks -> player_x saturates at 540 and never exceeds it; then dir=01 for 200 ticks -> player_x stops at 0.
- Force lane0 x=300, paddle at 270, let it fall -> on the resolving tick score=1, miss=0, obj_active[0]=0, lane respawns after 20 ticks. Repeat with paddle at 0 -> miss=1.
- N_OBJ=4, all lanes resolve as misses in one tick -> miss increments by 4 in a single cycle. With SCORE_W=3 -> score/miss saturate at 7.
- miss reaches 10 -> game_over=1 on that tick; subsequent ticks leave player_x and obj_y unchanged; state=3'b000 -> all outputs return to reset values.
- Mid-fall: state=3'b100 for 100 cycles -> obj_y and divider frozen. Back to 3'b010 -> resumes. rst=0 asserted mid-fall -> next cycle outputs at reset values.
